// File: rtl/convenc_frame_ctrl.sv
// Frame sequencer ahead of a K=7 rate-1/2 convolutional encoder: feeds din/dv_in,
// appends the K-1 zero tail, flushes after reset, and aligns sof/eof markers to dv_out.
module convenc_frame_ctrl #(
    parameter int K        = 7,
    parameter int ENC_LAT  = 2,
    parameter int MAX_BITS = 4096,
    parameter int GAP_CYC  = 0,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             s_last,
    output logic             enc_dv_in,
    output logic             enc_din,
    output logic             sym_sof,
    output logic             sym_eof,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             err_overlong,
    output logic             busy
);
    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_DATA, S_TAIL, S_GAP} state_t;

    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0]    TAIL_LAST = TW'(K - 2);
    localparam logic [GW-1:0]    GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_BITS);

    state_t             r_state;
    logic [TW-1:0]      r_tcnt;
    logic [GW-1:0]      r_gcnt;
    logic [LEN_W-1:0]   r_bcnt;
    logic [LEN_W-1:0]   r_len_pend;
    logic [LEN_W-1:0]   r_frame_len;
    logic               r_enc_dv;
    logic               r_enc_din;
    logic               r_err;
    logic               r_busy;
    // Index 0 is the tag riding with enc_dv_in; index ENC_LAT lines up with dv_out.
    logic [ENC_LAT:0]   r_sof_vld;
    logic [ENC_LAT:0]   r_eof_vld;

    logic               w_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_cnt_nx;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DATA);
    assign w_accept = s_valid & w_ready;
    assign w_cnt_nx = (r_state == S_IDLE) ? LEN_W'(1) : r_bcnt + LEN_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_FLUSH;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_bcnt      <= '0;
            r_len_pend  <= '0;
            r_frame_len <= '0;
            r_enc_dv    <= 1'b0;
            r_enc_din   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_sof_vld   <= '0;
            r_eof_vld   <= '0;
        end else begin
            r_enc_dv     <= 1'b0;
            r_enc_din    <= 1'b0;
            r_err        <= 1'b0;
            r_sof_vld[0] <= 1'b0;
            r_eof_vld[0] <= 1'b0;
            r_sof_vld[ENC_LAT:1] <= r_sof_vld[ENC_LAT-1:0];
            r_eof_vld[ENC_LAT:1] <= r_eof_vld[ENC_LAT-1:0];
            if (r_eof_vld[ENC_LAT-1])
                r_frame_len <= r_len_pend;

            case (r_state)
                S_FLUSH: begin
                    // Encoder shift register has no reset; push zeros through it.
                    r_enc_dv <= 1'b1;
                    if (r_tcnt == TAIL_LAST) begin
                        r_tcnt  <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                        r_busy <= 1'b1;
                    end
                end
                S_IDLE, S_DATA: begin
                    if (w_accept) begin
                        r_enc_dv     <= 1'b1;
                        r_enc_din    <= s_data;
                        r_sof_vld[0] <= (r_state == S_IDLE);
                        r_bcnt       <= w_cnt_nx;
                        r_busy       <= 1'b1;
                        if (s_last || (w_cnt_nx == MAX_L)) begin
                            r_len_pend <= w_cnt_nx;
                            r_err      <= ~s_last;
                            r_state    <= S_TAIL;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_TAIL: begin
                    r_enc_dv <= 1'b1;
                    if (r_tcnt == TAIL_LAST) begin
                        r_tcnt       <= '0;
                        r_eof_vld[0] <= 1'b1;
                        if (GAP_CYC > 0) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        r_gcnt  <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + GW'(1);
                    end
                end
                default: r_state <= S_FLUSH;
            endcase
        end
    end

    assign s_ready      = w_ready;
    assign enc_dv_in    = r_enc_dv;
    assign enc_din      = r_enc_din;
    assign sym_sof      = r_sof_vld[ENC_LAT];
    assign sym_eof      = r_eof_vld[ENC_LAT];
    assign frame_done   = r_eof_vld[ENC_LAT];
    assign frame_len    = r_frame_len;
    assign err_overlong = r_err;
    assign busy         = r_busy;
endmodule

// File: tb/tb_convenc_frame_ctrl.sv
// Directed bench for convenc_frame_ctrl with a G=171/133 encoder model on enc_din/enc_dv_in.
module tb_convenc_frame_ctrl;
    localparam int MAXB = 8;
    localparam int LW   = $clog2(MAXB + 1);

    logic clk = 1'b0, resetn = 1'b0;
    logic s_valid = 1'b0, s_data = 1'b0, s_last = 1'b0;
    logic s_ready, enc_dv_in, enc_din, sym_sof, sym_eof, frame_done, err_overlong, busy;
    logic [LW-1:0] frame_len;

    convenc_frame_ctrl #(.K(7), .ENC_LAT(2), .MAX_BITS(MAXB), .GAP_CYC(0)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .enc_dv_in(enc_dv_in), .enc_din(enc_din),
        .sym_sof(sym_sof), .sym_eof(sym_eof), .frame_done(frame_done),
        .frame_len(frame_len), .err_overlong(err_overlong), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    bit         q_din[$];
    int         q_dvc[$], q_sof[$], q_eof[$], q_done[$], q_err[$], q_len[$];
    logic [1:0] q_sym[$];
    logic [5:0] sr = 6'h3f;  // nonzero start so a missing flush shows up

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enc_dv_in) begin
            q_din.push_back(enc_din);
            q_dvc.push_back(cyc);
            q_sym.push_back({enc_din ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5],
                             enc_din ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5]});
            sr <= {sr[4:0], enc_din};
        end
        if (sym_sof) q_sof.push_back(cyc);
        if (sym_eof) begin q_eof.push_back(cyc); q_len.push_back(int'(frame_len)); end
        if (frame_done) q_done.push_back(cyc);
        if (err_overlong) q_err.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q_din.delete(); q_dvc.delete(); q_sym.delete(); q_sof.delete();
        q_eof.delete(); q_done.delete(); q_err.delete(); q_len.delete();
    endtask

    function automatic logic [31:0] pack_din();
        logic [31:0] v = '0;
        for (int i = 0; i < q_din.size(); i++) v = {v[30:0], q_din[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_sym();
        logic [31:0] v = '0;
        for (int i = 0; i < q_sym.size(); i++) v = {v[29:0], q_sym[i]};
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_bit(input logic d, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_in_time", (n < 50), 1);
        @(negedge clk);
        s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] f4 = 4'b1011;
        logic [9:0] f10 = 10'b1101001011;

        // reset state
        idle(3);
        chk("reset_outputs", {s_ready, enc_dv_in, enc_din, sym_sof, sym_eof, frame_done,
                              err_overlong, busy, frame_len}, 0);
        clr();
        resetn = 1'b1;
        idle(10);
        chk("flush_count", q_din.size(), 6);
        chk("flush_zeros", pack_din(), 0);
        chk("flush_contig", q_dvc[5] - q_dvc[0], 5);
        chk("flush_no_markers", q_sof.size() + q_eof.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", s_ready, 1);
        chk("flush_enc_state", sr, 0);

        // frame 1011, continuous
        clr();
        for (int i = 0; i < 4; i++) send_bit(f4[3-i], i == 3);
        idle(15);
        chk("f1_count", q_din.size(), 10);
        chk("f1_din", pack_din(), 32'b1011000000);
        chk("f1_contig", q_dvc[9] - q_dvc[0], 9);
        chk("f1_dout", pack_sym(), 32'hE251B);
        chk("f1_sof_n", q_sof.size(), 1);
        chk("f1_sof_cyc", q_sof[0], q_dvc[0] + 2);
        chk("f1_eof_cyc", q_eof[0], q_dvc[9] + 2);
        chk("f1_done_cyc", q_done[0], q_eof[0]);
        chk("f1_len_at_eof", q_len[0], 4);
        chk("f1_frame_len", frame_len, 4);
        chk("f1_no_err", q_err.size(), 0);

        // same frame, valid on alternate cycles
        clr();
        for (int i = 0; i < 4; i++) begin
            send_bit(f4[3-i], i == 3);
            if (i < 3) idle(1);
        end
        idle(15);
        chk("f2_count", q_din.size(), 10);
        chk("f2_din", pack_din(), 32'b1011000000);
        chk("f2_dout", pack_sym(), 32'hE251B);
        chk("f2_data_gaps", q_dvc[3] - q_dvc[0], 6);
        chk("f2_tail_contig", q_dvc[9] - q_dvc[3], 6);
        chk("f2_eof_cyc", q_eof[0], q_dvc[9] + 2);
        chk("f2_len", q_len[0], 4);

        // single-bit frame
        clr();
        send_bit(1'b1, 1'b1);
        idle(12);
        chk("f3_count", q_din.size(), 7);
        chk("f3_din", pack_din(), 32'b1000000);
        chk("f3_sof_cyc", q_sof[0], q_dvc[0] + 2);
        chk("f3_eof_cyc", q_eof[0], q_dvc[6] + 2);
        chk("f3_sof_eof_sep", q_eof[0] - q_sof[0], 6);
        chk("f3_len", q_len[0], 1);

        // 10 bits, no s_last until the 10th: truncation at MAX_BITS=8
        clr();
        for (int i = 0; i < 10; i++) send_bit(f10[9-i], i == 9);
        idle(20);
        chk("f4_count", q_din.size(), 22);
        chk("f4_din", pack_din(), 32'b1101001000000011000000);
        chk("f4_err_n", q_err.size(), 1);
        chk("f4_err_cyc", q_err[0], q_dvc[7]);
        chk("f4_sof_n", q_sof.size(), 2);
        chk("f4_sof2_cyc", q_sof[1], q_dvc[14] + 2);
        chk("f4_eof1_cyc", q_eof[0], q_dvc[13] + 2);
        chk("f4_len1", q_len[0], 8);
        chk("f4_len2", q_len[1], 2);
        chk("f4_frame_len", frame_len, 2);

        // reset during the 3rd data bit
        clr();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        s_valid = 1'b1; s_data = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_outputs", {s_ready, enc_dv_in, enc_din, sym_sof, sym_eof, frame_done,
                               err_overlong, busy, frame_len}, 0);
        s_valid = 1'b0; s_data = 1'b0;
        idle(3);
        chk("midrst_no_done", q_done.size() + q_eof.size(), 0);
        clr();
        resetn = 1'b1;
        idle(10);
        chk("f5_flush_count", q_din.size(), 6);
        chk("f5_flush_zeros", pack_din(), 0);
        chk("f5_no_markers", q_sof.size() + q_eof.size(), 0);
        clr();
        for (int i = 0; i < 4; i++) send_bit(f4[3-i], i == 3);
        idle(15);
        chk("f5_dout", pack_sym(), 32'hE251B);
        chk("f5_eof_n", q_eof.size(), 1);
        chk("f5_len", frame_len, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/convenc_frame_ctrl.md
Name: convenc_frame_ctrl

Overview:
- Frame sequencer in front of the half-rate convolutional encoder (K=7, G=171/133 octal).
- Accepts a bit-serial frame over a valid/ready handshake and drives the encoder's din/dv_in.
- Appends K-1 zero tail bits to terminate the trellis, and flushes the encoder shift register after reset.
- Emits start/end-of-frame markers aligned to the encoder's dv_out so downstream framing and Viterbi test benches see frame boundaries on the encoded symbol stream.

Parameters:
- K, 7, encoder constraint length; tail and flush length = K-1.
- ENC_LAT, 2, cycles from enc_dv_in to encoder dv_out.
- MAX_BITS, 4096, maximum data bits per frame (>=1).
- GAP_CYC, 0, idle cycles enforced after each frame's tail (0 = none).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input data bit valid.
- s_ready  out  1  controller accepts a bit this cycle.
- s_data  in  1  input data bit.
- s_last  in  1  marks the final data bit of the frame.
- enc_dv_in  out  1  to encoder dv_in; registered.
- enc_din  out  1  to encoder din; registered.
- sym_sof  out  1  high with the encoder dv_out of the first data symbol of a frame.
- sym_eof  out  1  high with the encoder dv_out of the last tail symbol of a frame.
- frame_done  out  1  one-cycle pulse, same cycle as sym_eof.
- frame_len  out  clog2(MAX_BITS+1)  data-bit count of the last completed frame; held until the next completion.
- err_overlong  out  1  one-cycle pulse when a frame is truncated at MAX_BITS.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, counters 0, marker pipeline cleared, state FLUSH. Reset mid-frame abandons the frame; no sof/eof/done is emitted for it.
- FLUSH: s_ready=0. Issue K-1 cycles of enc_dv_in=1, enc_din=0 with no markers, then go to IDLE. This clears the encoder shift register, which has no reset.
- IDLE: s_ready=1, busy=0. An accepted beat (s_valid & s_ready) at cycle t gives enc_dv_in=1 and enc_din=s_data at t+1. It sets the sof tag, sets the bit count to 1 and moves to DATA; if s_last is set, it moves to TAIL instead.
- DATA: s_ready=1.
  - Each accepted beat drives enc_dv_in=1 next cycle and increments the count.
  - Cycles without a beat drive enc_dv_in=0; the encoder holds.
  - When the beat has s_last=1, or the count reaches MAX_BITS: latch frame_len and go to TAIL.
  - Reaching MAX_BITS without s_last also pulses err_overlong, and further input bits are taken as a new frame after the tail.
- TAIL: s_ready=0. Issue K-1 consecutive cycles of enc_dv_in=1, enc_din=0. The final tail bit carries the eof tag. Then go to GAP if GAP_CYC>0, else IDLE.
- GAP: s_ready=0, enc_dv_in=0 for GAP_CYC cycles, then IDLE.
- Marker pipeline:
  - sof/eof tags travel an ENC_LAT-deep shift register clocked every cycle.
  - sym_sof and sym_eof therefore assert exactly ENC_LAT cycles after the enc_dv_in carrying the tag.
  - frame_done equals sym_eof; frame_len updates on the same cycle.
- A one-bit frame (first beat has s_last) gives sof and eof tags on different bits: data bit, then 6 tail bits.
- Encoded symbols per frame = N + K-1, contiguous in time from the tail start only. Data symbols may have gaps if s_valid stalls.
- s_data and s_last are ignored when s_valid=0. A held s_valid while s_ready=0 is not consumed.

Test Plan:
- Release reset, hold s_valid=0 -> 6 cycles enc_dv_in=1 with enc_din=0, no sym_sof/sym_eof, then busy=0, s_ready=1.
- Frame 1,0,1,1 (last on 4th), s_valid continuous -> enc_din 1,0,1,1,0,0,0,0,0,0 on 10 consecutive enc_dv_in cycles; encoder dout matches G=171/133 reference model; sym_sof 2 cycles after the first enc_dv_in; sym_eof and frame_done 2 cycles after the 10th; frame_len=4.
- Same frame with s_valid low on alternate cycles -> enc_dv_in gaps in the data phase only, identical dout sequence, frame_len=4.
- Single-bit frame (s_data=1, s_last=1) -> 7 enc_dv_in cycles; sof and eof markers 6 symbols apart; frame_len=1.
- MAX_BITS=8, 10 bits with no s_last -> err_overlong pulse on the 8th accept; 6 tail bits; frame_len=8; remaining 2 bits start a new frame with sym_sof.
- resetn low during the 3rd data bit -> all outputs 0 immediately; no frame_done; after release the 6-bit FLUSH repeats and the next frame encodes correctly from zero state.
